jam_solver: RTL and testbench

Parametrised exhaustive job-assignment solver, the successor of the fixed 8×8 JAM engine. It enumerates all N! worker-to-job permutations in lexicographic order and reads per-assignment costs from an external combinational cost ROM. It reports the optimum total cost, the number of permutations reaching it, and the first optimal permutation. New over the previous generation: configurable N and cost width, a min/max mode, a START/Busy handshake, and a best-permutation output.

---
 rtl/jam_solver_pkg.sv | 24 ++
 rtl/jam_solver_if.sv | 35 +++
 rtl/jam_solver_next_perm.sv | 46 ++++
 rtl/jam_solver.sv | 150 +++++++++++++++
 tb/tb_jam_solver.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/jam_solver_pkg.sv
// jam_pkg: shared types and constants for the jam_solver block.
//   state_t        : solver FSM states
//   MODE_MIN/MAX   : encodings of the MODE input
//   fact(n)        : n! (used by benches to size expected match counts)
package jam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SWAP,
    REV,
    DONE
  } state_t;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  function automatic int unsigned fact(input int unsigned n);
    int unsigned r = 1;
    for (int unsigned i = 2; i <= n; i++) r = r * i;
    return r;
  endfunction

endpackage

// File: rtl/jam_solver_if.sv
// jam_solver_if: control, cost-ROM and result signals of jam_solver.
//   START/MODE      : search request and min/max select (into solver)
//   W/J/Cost        : cost ROM address (out) and combinational data (in)
//   Busy/Valid      : status; Valid pulses one cycle when results are final
//   BestCost/MatchCount/BestPerm : search results
// master = solver side, slave = environment (requester + ROM) side.
interface jam_solver_if #(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int CNT_W  = 16
);
  localparam int IDX_W = $clog2(N);
  localparam int ACC_W = COST_W + $clog2(N) + 1;

  logic                START;
  logic                MODE;
  logic [IDX_W-1:0]    W;
  logic [IDX_W-1:0]    J;
  logic [COST_W-1:0]   Cost;
  logic                Busy;
  logic                Valid;
  logic [ACC_W-1:0]    BestCost;
  logic [CNT_W-1:0]    MatchCount;
  logic [N*IDX_W-1:0]  BestPerm;

  modport master (
    input  START, MODE, Cost,
    output W, J, Busy, Valid, BestCost, MatchCount, BestPerm
  );

  modport slave (
    output START, MODE, Cost,
    input  W, J, Busy, Valid, BestCost, MatchCount, BestPerm
  );
endinterface

// File: rtl/jam_solver_next_perm.sv
// jam_next_perm: combinational next-lexicographic-permutation helper.
//   perm_i : packed permutation, slice k = job of worker k
//   p_o    : pivot, largest index with perm[p] < perm[p+1]
//   q_o    : index of smallest value right of p exceeding perm[p]
//   last_o : perm is fully descending (no successor)
module jam_next_perm #(
  parameter int N = 8
) (
  input  logic [N*$clog2(N)-1:0] perm_i,
  output logic [$clog2(N)-1:0]   p_o,
  output logic [$clog2(N)-1:0]   q_o,
  output logic                   last_o
);
  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] v [N];
  logic [IDX_W-1:0] pv;
  logic [IDX_W-1:0] best;
  logic             found;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) v[i] = perm_i[i*IDX_W +: IDX_W];

    last_o = 1'b1;
    p_o    = '0;
    for (int unsigned i = 0; i + 1 < N; i++) begin
      if (v[i] < v[i+1]) begin
        last_o = 1'b0;
        p_o    = IDX_W'(i);
      end
    end

    // Ties cannot occur in a permutation; <= keeps the highest index anyway.
    pv    = v[p_o];
    found = 1'b0;
    best  = '0;
    q_o   = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (j > 32'(p_o) && v[j] > pv && (!found || v[j] <= best)) begin
        found = 1'b1;
        best  = v[j];
        q_o   = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/jam_solver.sv
// jam_solver: exhaustive N x N job-assignment solver.
//   CLK, RST_N : clock, synchronous active-low reset
//   bus        : jam_solver_if.master (START/MODE in, W/J/Cost ROM port,
//                Busy/Valid status, BestCost/MatchCount/BestPerm results)
// Optional build macro JAM_PRUNE_EN: in min mode, abandon a permutation as
// soon as its partial sum exceeds the current best (results unchanged).
module jam_solver
  import jam_pkg::*;
#(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int CNT_W  = 16
) (
  input logic         CLK,
  input logic         RST_N,
  jam_solver_if.master bus
);
  localparam int IDX_W = $clog2(N);
  localparam int ACC_W = COST_W + $clog2(N) + 1;
  localparam int PW    = N * IDX_W;
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N - 1);

  function automatic logic [PW-1:0] ident();
    logic [PW-1:0] r;
    for (int unsigned k = 0; k < N; k++) r[k*IDX_W +: IDX_W] = IDX_W'(k);
    return r;
  endfunction

  localparam logic [PW-1:0] IDENT = ident();

  state_t           state_q, state_d;
  logic [PW-1:0]    perm_q, perm_swp, perm_rev, bperm_q;
  logic [IDX_W-1:0] rd_q, piv_q, piv, swp;
  logic             last, mode_q, prune, better;
  logic [ACC_W-1:0] acc_q, total, best_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, valid_q;

  jam_next_perm #(.N(N)) u_next (
    .perm_i (perm_q),
    .p_o    (piv),
    .q_o    (swp),
    .last_o (last)
  );

  // Read 0 of each permutation restarts the sum rather than adding to it.
  assign total  = ((rd_q == '0) ? '0 : acc_q) + ACC_W'(bus.Cost);
  assign better = (mode_q == MODE_MAX) ? (total > best_q) : (total < best_q);

`ifdef JAM_PRUNE_EN
  assign prune = (mode_q == MODE_MIN) && (rd_q != '0) && (total > best_q);
`else
  assign prune = 1'b0;
`endif

  always_comb begin
    perm_swp = perm_q;
    perm_swp[piv*IDX_W +: IDX_W] = perm_q[swp*IDX_W +: IDX_W];
    perm_swp[swp*IDX_W +: IDX_W] = perm_q[piv*IDX_W +: IDX_W];
    perm_rev = perm_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (i > 32'(piv_q))
        perm_rev[i*IDX_W +: IDX_W] = perm_q[(N + 32'(piv_q) - i)*IDX_W +: IDX_W];
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.START) state_d = READ;
      READ: if (rd_q == LAST_K || prune) state_d = last ? DONE : SWAP;
      SWAP: state_d = REV;
      REV:  state_d = READ;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ROM address is combinational from state and read count
  always_comb begin
    bus.W = '0;
    bus.J = '0;
    if (state_q == READ) begin
      bus.W = rd_q;
      bus.J = perm_q[rd_q*IDX_W +: IDX_W];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      perm_q  <= IDENT;
      acc_q   <= '0;
      rd_q    <= '0;
      piv_q   <= '0;
      mode_q  <= MODE_MIN;
      best_q  <= '1;
      cnt_q   <= '0;
      bperm_q <= IDENT;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      busy_q  <= (state_d != IDLE);
      valid_q <= (state_d == DONE);
      unique case (state_q)
        IDLE: if (bus.START) begin
          perm_q <= IDENT;
          mode_q <= bus.MODE;
          acc_q  <= '0;
          rd_q   <= '0;
          best_q <= (bus.MODE == MODE_MAX) ? '0 : '1;
          cnt_q  <= '0;
        end
        READ: if (!prune) begin
          if (rd_q == LAST_K) begin
            if (better) begin
              best_q  <= total;
              cnt_q   <= CNT_W'(1);
              bperm_q <= perm_q;
            end else if (total == best_q && cnt_q != '1) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            acc_q <= total;
            rd_q  <= rd_q + 1'b1;
          end
        end
        SWAP: begin
          perm_q <= perm_swp;
          piv_q  <= piv;
          rd_q   <= '0;
        end
        REV:  perm_q <= perm_rev;
        default: ;
      endcase
    end
  end

  assign bus.Busy       = busy_q;
  assign bus.Valid      = valid_q;
  assign bus.BestCost   = best_q;
  assign bus.MatchCount = cnt_q;
  assign bus.BestPerm   = bperm_q;
endmodule

// File: tb/tb_jam_solver.sv
module tb_jam_solver;
  import jam_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mat4 = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc;

  always #5 clk = ~clk;

  jam_solver_if #(.N(3), .COST_W(7), .CNT_W(16)) b3 ();
  jam_solver_if #(.N(4), .COST_W(7), .CNT_W(16)) b4 ();

  jam_solver #(.N(3), .COST_W(7), .CNT_W(16)) u3 (.CLK(clk), .RST_N(rst_n), .bus(b3));
  jam_solver #(.N(4), .COST_W(7), .CNT_W(16)) u4 (.CLK(clk), .RST_N(rst_n), .bus(b4));

  // N=3 ROM: rows {1,2,3},{2,4,6},{3,6,9}
  assign b3.Cost = 7'((32'(b3.W) + 1) * (32'(b3.J) + 1));
  // N=4 ROM: all 5, or 1 where J == W+1 (mod 4) and 3 elsewhere
  assign b4.Cost = !mat4 ? 7'd5 : ((b4.J == 2'(b4.W + 2'd1)) ? 7'd1 : 7'd3);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start3(input logic m);
    b3.MODE  = m;
    b3.START = 1'b1;
    @(posedge clk); #1;
    b3.START = 1'b0;
  endtask

  task automatic start4(input logic m);
    b4.MODE  = m;
    b4.START = 1'b1;
    @(posedge clk); #1;
    b4.START = 1'b0;
  endtask

  task automatic wait3(input int c0, output int c);
    c = c0;
    while (!b3.Valid && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic wait4(input int c0, output int c);
    c = c0;
    while (!b4.Valid && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  initial begin
    b3.START = 1'b0; b3.MODE = 1'b0;
    b4.START = 1'b0; b4.MODE = 1'b0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_busy",  32'(b3.Busy), 32'd0);
    check("rst_valid", 32'(b3.Valid), 32'd0);
    check("rst_w",     32'(b3.W), 32'd0);
    check("rst_j",     32'(b3.J), 32'd0);
    check("rst_best",  32'(b3.BestCost), 32'h3FF);
    check("rst_cnt",   32'(b3.MatchCount), 32'd0);
    check("rst_perm3", 32'(b3.BestPerm), 32'h24);
    check("rst_perm4", 32'(b4.BestPerm), 32'hE4);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // N=3 minimise
    start3(MODE_MIN);
    check("min3_busy_c1", 32'(b3.Busy), 32'd1);
    check("min3_w_c1", 32'(b3.W), 32'd0);
    check("min3_j_c1", 32'(b3.J), 32'd0);
    @(posedge clk); #1;
    check("min3_w_c2", 32'(b3.W), 32'd1);
    check("min3_j_c2", 32'(b3.J), 32'd1);
    wait3(2, cyc);
    check("min3_best", 32'(b3.BestCost), 32'd10);
    check("min3_cnt",  32'(b3.MatchCount), 32'd1);
    check("min3_perm", 32'(b3.BestPerm), 32'h06);
`ifndef JAM_PRUNE_EN
    check("min3_cycles", 32'(cyc), 32'd29);
`endif
    @(posedge clk); #1;
    check("min3_valid_fall", 32'(b3.Valid), 32'd0);
    check("min3_busy_fall",  32'(b3.Busy), 32'd0);
    repeat (3) @(posedge clk); #1;
    check("min3_hold", 32'(b3.BestCost), 32'd10);

    // N=3 maximise (never pruned)
    start3(MODE_MAX);
    wait3(1, cyc);
    check("max3_best", 32'(b3.BestCost), 32'd14);
    check("max3_cnt",  32'(b3.MatchCount), 32'd1);
    check("max3_perm", 32'(b3.BestPerm), 32'h24);
    check("max3_cycles", 32'(cyc), 32'd29);
    @(posedge clk); #1;

    // N=4 all-equal costs: every permutation ties, nothing pruned
    mat4 = 1'b0;
    start4(MODE_MIN);
    wait4(1, cyc);
    check("eq4_best", 32'(b4.BestCost), 32'd20);
    check("eq4_cnt",  32'(b4.MatchCount), fact(4));
    check("eq4_perm", 32'(b4.BestPerm), 32'hE4);
    check("eq4_cycles", 32'(cyc), 32'd143);
    @(posedge clk); #1;

    // N=4 shifted matrix, minimise: unique optimum {1,2,3,0}
    mat4 = 1'b1;
    start4(MODE_MIN);
    wait4(1, cyc);
    check("sh4min_best", 32'(b4.BestCost), 32'd4);
    check("sh4min_cnt",  32'(b4.MatchCount), 32'd1);
    check("sh4min_perm", 32'(b4.BestPerm), 32'h39);
    @(posedge clk); #1;

    // N=4 shifted matrix, maximise: 9 derangements cost 12, identity first
    start4(MODE_MAX);
    wait4(1, cyc);
    check("sh4max_best", 32'(b4.BestCost), 32'd12);
    check("sh4max_cnt",  32'(b4.MatchCount), 32'd9);
    check("sh4max_perm", 32'(b4.BestPerm), 32'hE4);
    check("sh4max_cycles", 32'(cyc), 32'd143);
    @(posedge clk); #1;

    // Reset mid-search, then a fresh run
    start3(MODE_MIN);
    repeat (24) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy",  32'(b3.Busy), 32'd0);
    check("midrst_valid", 32'(b3.Valid), 32'd0);
    check("midrst_w",     32'(b3.W), 32'd0);
    check("midrst_j",     32'(b3.J), 32'd0);
    check("midrst_best",  32'(b3.BestCost), 32'h3FF);
    check("midrst_cnt",   32'(b3.MatchCount), 32'd0);
    check("midrst_perm",  32'(b3.BestPerm), 32'h24);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start3(MODE_MIN);
    wait3(1, cyc);
    check("rerun_best", 32'(b3.BestCost), 32'd10);
    check("rerun_cnt",  32'(b3.MatchCount), 32'd1);
    check("rerun_perm", 32'(b3.BestPerm), 32'h06);
`ifndef JAM_PRUNE_EN
    check("rerun_cycles", 32'(cyc), 32'd29);
`endif
    @(posedge clk); #1;

    // START and MODE activity while busy are ignored
    start3(MODE_MIN);
    repeat (4) @(posedge clk); #1;
    b3.START = 1'b1;
    b3.MODE  = MODE_MAX;
    @(posedge clk); #1;
    b3.START = 1'b0;
    b3.MODE  = MODE_MIN;
    @(posedge clk); #1;
    b3.MODE  = MODE_MAX;
    wait3(7, cyc);
    check("ign_best", 32'(b3.BestCost), 32'd10);
    check("ign_cnt",  32'(b3.MatchCount), 32'd1);
    check("ign_perm", 32'(b3.BestPerm), 32'h06);
`ifndef JAM_PRUNE_EN
    check("ign_cycles", 32'(cyc), 32'd29);
`endif
    @(posedge clk); #1;
    check("ign_idle", 32'(b3.Busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
